iom_bus_master: RTL and testbench

Bus initiator for the IOM memory/IO bus; converts single-beat requests from a host-side client into ALE/cs/RD/WR bus cycles. It drives the 20-bit address, the chip-selects and the 8-bit bidirectional data bus toward up to four IOM responders (two memory, two IO). It returns read data and a one-cycle completion pulse to the client.

---
 rtl/iom_bus_master.sv | 113 +++++++++++
 tb/tb_iom_bus_master.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/iom_bus_master.sv
// rtl/iom_bus_master.sv - IOM bus initiator: single-beat client requests to ALE/cs/RD/WR bus cycles
`timescale 1ns/1ps
module iom_bus_master #(
  parameter int Add_width   = 20,
  parameter int Data_width  = 8,
  parameter int NUM_CS      = 4,
  parameter int WAIT_STATES = 0
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  we,
  input  logic [Add_width-1:0]  addr_in,
  input  logic [Data_width-1:0] wdata,
  output logic                  ready,
  output logic                  done,
  output logic [Data_width-1:0] rdata,
  output logic                  ALE,
  output logic                  RD,
  output logic                  WR,
  output logic [NUM_CS-1:0]     cs,
  output logic [Add_width-1:0]  Addr,
  inout  wire  [Data_width-1:0] data
);

  typedef enum logic [2:0] {IDLE, T1, T2, T3, T4} state_t;

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_t                state, state_n;
  logic                  accept;
  logic                  we_q, we_n;
  logic [Data_width-1:0] wdata_q;
  logic [3:0]            wcnt;
  logic                  oe;
  logic                  strobe_n, ale_n, rd_n, wr_n, oe_n, done_n, ready_n;
  logic [NUM_CS-1:0]     cs_n;
  logic [Add_width-1:0]  addr_n;
  logic [1:0]            sel_n;

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Output values are derived from the state being entered so every output is a flop.
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_n = T1;
        accept  = 1'b1;
      end
      T1:      state_n = T2;
      T2:      state_n = T3;
      T3:      if (wcnt == 4'd0) state_n = T4;
      T4:      state_n = IDLE;
      default: state_n = IDLE;
    endcase

    we_n     = accept ? we : we_q;
    addr_n   = accept ? addr_in : Addr;
    sel_n    = addr_n[Add_width-1 -: 2];
    strobe_n = (state_n == T2) || (state_n == T3);
    ale_n    = (state_n == T1);
    rd_n     = strobe_n && !we_n;
    wr_n     = strobe_n && we_n;
    oe_n     = we_n && (strobe_n || (state_n == T4));
    done_n   = (state_n == T4);
    ready_n  = (state_n == IDLE);
    cs_n     = '0;
    if (ale_n || strobe_n) cs_n[sel_n] = 1'b1;
  end

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      ready   <= 1'b1;
      done    <= 1'b0;
      ALE     <= 1'b0;
      RD      <= 1'b0;
      WR      <= 1'b0;
      cs      <= '0;
      Addr    <= '0;
      rdata   <= '0;
      oe      <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      wcnt    <= 4'd0;
    end else begin
      ready <= ready_n;
      done  <= done_n;
      ALE   <= ale_n;
      RD    <= rd_n;
      WR    <= wr_n;
      cs    <= cs_n;
      Addr  <= addr_n;
      oe    <= oe_n;
      we_q  <= we_n;
      if (accept) wdata_q <= wdata;
      if (state == T2)
        wcnt <= WS_LOAD;
      else if (state == T3 && wcnt != 4'd0)
        wcnt <= wcnt - 4'd1;
      // Sample the responder on the edge that closes the last T3 cycle.
      if (state == T3 && wcnt == 4'd0 && !we_q)
        rdata <= data;
    end
  end

  assign data = oe ? wdata_q : {Data_width{1'bz}};

endmodule

// File: tb/tb_iom_bus_master.sv
// tb/tb_iom_bus_master.sv - bench for iom_bus_master with 0 and 3 wait states against a memory model
`timescale 1ns/1ps
module tb_iom_bus_master;

  localparam logic [7:0] REL = 8'hFF;  // pulled-up value of a released bus

  logic CLK = 1'b0;
  logic rst = 1'b0;
  always #5 CLK = ~CLK;

  logic        req[2], we[2];
  logic [19:0] ain[2];
  logic [7:0]  wd[2];
  logic        rdy[2], dn[2], ale[2], rd[2], wr[2];
  logic [3:0]  csv[2];
  logic [19:0] addr_o[2];
  logic [7:0]  rdat[2];
  wire  [7:0]  data0, data1;

  logic [7:0]  mem [0:1023];
  logic [7:0]  ref_mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = '0;
  logic [7:0]  pl_val = '0;
  logic [7:0]  last_rd[2];
  int          ksel = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  longint      t_done = 0;

  wire [7:0] dview = (ksel == 1) ? data1 : data0;
  wire [9:0] idx0 = {addr_o[0][19:18], addr_o[0][7:0]};
  wire [9:0] idx1 = {addr_o[1][19:18], addr_o[1][7:0]};

  iom_bus_master #(.WAIT_STATES(0)) u_dut0 (
    .CLK(CLK), .rst(rst), .req(req[0]), .we(we[0]), .addr_in(ain[0]), .wdata(wd[0]),
    .ready(rdy[0]), .done(dn[0]), .rdata(rdat[0]), .ALE(ale[0]), .RD(rd[0]), .WR(wr[0]),
    .cs(csv[0]), .Addr(addr_o[0]), .data(data0));

  iom_bus_master #(.WAIT_STATES(3)) u_dut3 (
    .CLK(CLK), .rst(rst), .req(req[1]), .we(we[1]), .addr_in(ain[1]), .wdata(wd[1]),
    .ready(rdy[1]), .done(dn[1]), .rdata(rdat[1]), .ALE(ale[1]), .RD(rd[1]), .WR(wr[1]),
    .cs(csv[1]), .Addr(addr_o[1]), .data(data1));

  pullup pu0 (data0);
  pullup pu1 (data1);

  // Responders: four 256-byte IOMs per bus, selected by cs, decoding Addr[7:0].
  assign data0 = (rd[0] && csv[0] != 4'd0) ? mem[idx0] : 8'bz;
  assign data1 = (rd[1] && csv[1] != 4'd0) ? mem[idx1] : 8'bz;

  always @(posedge CLK) begin
    if (pl_en) mem[pl_idx] <= pl_val;
    else begin
      if (wr[0] && csv[0] != 4'd0) mem[idx0] <= data0;
      if (wr[1] && csv[1] != 4'd0) mem[idx1] <= data1;
    end
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction on instance k; called right after a falling edge.
  task automatic xfer(int k, bit w, logic [19:0] a, logic [7:0] d,
                      bit hold, bit poke, int abort_n);
    int         ws = (k == 1) ? 3 : 0;
    logic [9:0] mi = {a[19:18], a[7:0]};
    logic [3:0] exp_cs = 4'b0001 << a[19:18];
    logic [7:0] exp_rd = w ? last_rd[k] : ref_mem[mi];
    logic [7:0] exp_dat;
    ksel = k;
    req[k] = 1'b1; we[k] = w; ain[k] = a; wd[k] = d;
    for (int n = 1; n <= 5 + ws; n++) begin
      @(negedge CLK);
      if (n == 1 && !hold) req[k] = 1'b0;
      if (poke && n == 2) begin req[k] = 1'b1; ain[k] = 20'h0_0001; end
      if (poke && n == 3) req[k] = 1'b0;
      if (w && n >= 2 && n <= 4 + ws)       exp_dat = d;
      else if (!w && n >= 2 && n <= 3 + ws) exp_dat = exp_rd;
      else                                  exp_dat = REL;
      chk("ready", rdy[k], n == 5 + ws);
      chk("ALE",   ale[k], n == 1);
      chk("RD",    rd[k],  !w && n >= 2 && n <= 3 + ws);
      chk("WR",    wr[k],  w && n >= 2 && n <= 3 + ws);
      chk("cs",    csv[k], (n <= 3 + ws) ? exp_cs : 4'd0);
      chk("Addr",  addr_o[k], a);
      chk("done",  dn[k],  n == 4 + ws);
      chk("data",  dview,  exp_dat);
      if (n == 4 + ws) begin
        chk("rdata", rdat[k], exp_rd);
        t_done = $time;
      end
      if (n == abort_n) begin
        rst = 1'b0;
        #1;
        chk("rst_ALE", ale[k], 0);
        chk("rst_RD",  rd[k],  0);
        chk("rst_WR",  wr[k],  0);
        chk("rst_cs",  csv[k], 0);
        chk("rst_done", dn[k], 0);
        chk("rst_data", dview, REL);
        @(negedge CLK);
        rst = 1'b1;
        if (w && n >= 3) ref_mem[mi] = d;  // responder latched the strobe before the abort
        last_rd[0] = '0;
        last_rd[1] = '0;
        return;
      end
    end
    if (w) ref_mem[mi] = d;
    else   last_rd[k] = exp_rd;
  endtask

  task automatic idle_check(int k, int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      chk("idle_ready", rdy[k], 1);
      chk("idle_ALE",   ale[k], 0);
      chk("idle_done",  dn[k],  0);
    end
  endtask

  initial begin
    longint t1, t2, t3;
    for (int k = 0; k < 2; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; ain[k] = '0; wd[k] = '0; last_rd[k] = '0;
    end
    // Preload the responders (and the model) while the masters sit in reset.
    for (int i = 0; i < 1024; i++) begin
      @(negedge CLK);
      pl_en  = 1'b1;
      pl_idx = 10'(i);
      pl_val = (i == 10'h3FF) ? 8'h3C : 8'($urandom);
      ref_mem[i] = pl_val;
    end
    @(negedge CLK);
    pl_en = 1'b0;

    for (int k = 0; k < 2; k++) begin
      ksel = k;
      #1;
      chk("rst_ready", rdy[k], 1);
      chk("rst_done",  dn[k],  0);
      chk("rst_ALE",   ale[k], 0);
      chk("rst_RD",    rd[k],  0);
      chk("rst_WR",    wr[k],  0);
      chk("rst_cs",    csv[k], 0);
      chk("rst_Addr",  addr_o[k], 0);
      chk("rst_rdata", rdat[k], 0);
      chk("rst_data",  dview, REL);
    end
    @(negedge CLK);
    rst = 1'b1;

    xfer(0, 1'b1, 20'h4_0010, 8'hA5, 1'b0, 1'b0, 0);
    xfer(0, 1'b0, 20'h4_0010, 8'h00, 1'b0, 1'b0, 0);
    chk("readback", rdat[0], 8'hA5);

    xfer(1, 1'b0, 20'hC_00FF, 8'h00, 1'b0, 1'b0, 0);
    chk("ws_read", rdat[1], 8'h3C);

    xfer(0, 1'b1, 20'h8_0020, 8'h5A, 1'b0, 1'b1, 0);
    idle_check(0, 2);
    xfer(0, 1'b0, 20'h0_0001, 8'h00, 1'b0, 1'b0, 0);

    xfer(0, 1'b1, 20'h1_2345, 8'h11, 1'b1, 1'b0, 0);
    t1 = t_done;
    xfer(0, 1'b1, 20'h5_6789, 8'h22, 1'b1, 1'b0, 0);
    t2 = t_done;
    xfer(0, 1'b0, 20'h1_2345, 8'h00, 1'b0, 1'b0, 0);
    t3 = t_done;
    chk("b2b_gap1", 32'(t2 - t1), 50);
    chk("b2b_gap2", 32'(t3 - t2), 50);
    idle_check(0, 1);

    for (int i = 0; i < 24; i++)
      xfer($urandom_range(0, 1), 1'($urandom_range(0, 1)), 20'($urandom), 8'($urandom),
           1'b0, 1'b0, 0);

    xfer(0, 1'b1, 20'h9_0042, 8'h77, 1'b0, 1'b0, 3);
    chk("post_rst_rdata", rdat[0], 0);
    idle_check(0, 3);
    xfer(0, 1'b0, 20'hD_0043, 8'h00, 1'b0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
